// File: rtl/cpu_pkg.sv
// Shared definitions for the pico_cpu: instruction format, opcodes, fixed-point constants
// and the shipped affine-transform program image.
package cpu_pkg;

    localparam int N_DEFAULT = 8;
    localparam int GPR_COUNT = 4;
    localparam int Q_SHIFT   = 6;
    localparam int Q_ROUND   = 32;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_MOV   = 4'h2,
        OP_ADD   = 4'h3,
        OP_ADDI  = 4'h4,
        OP_MACI  = 4'h5,
        OP_IN    = 4'h6,
        OP_OUT   = 4'h7,
        OP_WAITH = 4'h8,
        OP_WAITL = 4'h9,
        OP_JMP   = 4'hA
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } instr_t;

    function automatic instr_t mk(input op_t op, input logic [1:0] rd,
                                  input logic [1:0] rs, input logic [7:0] imm);
        instr_t i;
        i.op  = op;
        i.rd  = rd;
        i.rs  = rs;
        i.imm = imm;
        return i;
    endfunction

    // r0/r1 hold the x2/y2 offsets before any wait so both results fit the latency budget.
    // r2 = x1, r3 = y1. Coefficients are Q1.6: 48 = 0.75, 32 = 0.5, 0xE0 = -0.5.
    function automatic instr_t shipped_prog(input logic [15:0] addr);
        instr_t i;
        i = mk(OP_NOP, 2'd0, 2'd0, 8'h00);
        case (addr)
            16'd0:  i = mk(OP_LDI,   2'd0, 2'd0, 8'd20);
            16'd1:  i = mk(OP_LDI,   2'd1, 2'd0, 8'hEC);
            16'd2:  i = mk(OP_WAITH, 2'd0, 2'd0, 8'h00);
            16'd3:  i = mk(OP_IN,    2'd2, 2'd0, 8'h00);
            16'd4:  i = mk(OP_WAITL, 2'd0, 2'd0, 8'h00);
            16'd5:  i = mk(OP_WAITH, 2'd0, 2'd0, 8'h00);
            16'd6:  i = mk(OP_IN,    2'd3, 2'd0, 8'h00);
            16'd7:  i = mk(OP_WAITL, 2'd0, 2'd0, 8'h00);
            16'd8:  i = mk(OP_MACI,  2'd0, 2'd2, 8'd48);
            16'd9:  i = mk(OP_MACI,  2'd0, 2'd3, 8'd32);
            16'd10: i = mk(OP_OUT,   2'd0, 2'd0, 8'h00);
            16'd11: i = mk(OP_WAITH, 2'd0, 2'd0, 8'h00);
            16'd12: i = mk(OP_MACI,  2'd1, 2'd2, 8'hE0);
            16'd13: i = mk(OP_MACI,  2'd1, 2'd3, 8'd48);
            16'd14: i = mk(OP_OUT,   2'd0, 2'd1, 8'h00);
            16'd15: i = mk(OP_WAITL, 2'd0, 2'd0, 8'h00);
            16'd16: i = mk(OP_JMP,   2'd0, 2'd0, 8'd0);
            default: ;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/pico_cpu_gpr.sv
// Four-entry general purpose register file: one synchronous write port,
// two combinational read ports, synchronous active-high reset.
module gpr
    import cpu_pkg::*;
#(
    parameter int n = N_DEFAULT
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         we,
    input  logic [1:0]   waddr,
    input  logic [n-1:0] wdata,
    input  logic [1:0]   raddr_a,
    input  logic [1:0]   raddr_b,
    output logic [n-1:0] rdata_a,
    output logic [n-1:0] rdata_b
);

    logic [n-1:0] gpr [GPR_COUNT];

    always_ff @(posedge clk) begin
        if (nReset) begin
            for (int i = 0; i < GPR_COUNT; i++) begin
                gpr[i] <= '0;
            end
        end else if (we) begin
            gpr[waddr] <= wdata;
        end
    end

    assign rdata_a = gpr[raddr_a];
    assign rdata_b = gpr[raddr_b];

endmodule

// File: rtl/pico_cpu.sv
// Minimal 8-bit single-cycle processor: program counter, program ROM, decode/ALU
// and registered output port around the gpr register file.
module pico_cpu
    import cpu_pkg::*;
#(
    parameter int n          = N_DEFAULT,
    parameter     PROG_FILE  = "prog.hex",
    parameter int PROG_DEPTH = 256
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic [n:0]   inport,
    output logic [n-1:0] outport
);

    localparam int aw = $clog2(PROG_DEPTH);
    // An empty image name leaves the ROM blank (all NOP); any name selects the shipped program.
    localparam bit rom_loaded = |PROG_FILE;

    logic [aw-1:0]          progAddr;
    logic [aw-1:0]          pc_inc;
    logic [aw-1:0]          pc_next;
    instr_t                 instr;
    logic [n-1:0]           rd_val;
    logic [n-1:0]           rs_val;
    logic [n-1:0]           wdata;
    logic                   we;
    logic                   out_we;
    logic                   ready;
    logic signed [7:0]      imm_s;
    logic signed [n-1:0]    imm_ext;
    logic signed [2*n-1:0]  prod;
    logic [n-1:0]           mac_term;

    assign instr = rom_loaded ? shipped_prog(16'(progAddr)) : '0;

    // Handshake: inport[n] is a level flag owned by the host; data on inport[n-1:0] is
    // valid while the flag is high, and the program paces itself with WAITH/WAITL on it.
    assign ready = inport[n];

    assign imm_s    = signed'(instr.imm);
    assign imm_ext  = n'(imm_s);
    assign prod     = (2*n)'(signed'(rs_val)) * (2*n)'(imm_ext);
    assign mac_term = n'((prod + (2*n)'(Q_ROUND)) >>> Q_SHIFT);

    gpr #(.n(n)) gpr (
        .clk     (clk),
        .nReset  (nReset),
        .we      (we),
        .waddr   (instr.rd),
        .wdata   (wdata),
        .raddr_a (instr.rd),
        .raddr_b (instr.rs),
        .rdata_a (rd_val),
        .rdata_b (rs_val)
    );

    always_comb begin
        pc_inc  = (progAddr == aw'(PROG_DEPTH - 1)) ? '0 : progAddr + aw'(1);
        pc_next = pc_inc;
        we      = 1'b0;
        wdata   = '0;
        out_we  = 1'b0;
        case (instr.op)
            OP_LDI:   begin we = 1'b1; wdata = imm_ext;           end
            OP_MOV:   begin we = 1'b1; wdata = rs_val;            end
            OP_ADD:   begin we = 1'b1; wdata = rd_val + rs_val;   end
            OP_ADDI:  begin we = 1'b1; wdata = rd_val + imm_ext;  end
            OP_MACI:  begin we = 1'b1; wdata = rd_val + mac_term; end
            OP_IN:    begin we = 1'b1; wdata = inport[n-1:0];     end
            OP_OUT:   out_we = 1'b1;
            OP_WAITH: if (!ready) pc_next = progAddr;
            OP_WAITL: if (ready)  pc_next = progAddr;
            OP_JMP:   pc_next = aw'(instr.imm);
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            progAddr <= '0;
            outport  <= '0;
        end else begin
            progAddr <= pc_next;
            if (out_we) begin
                outport <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_pico_cpu.sv
// Bench for pico_cpu running the shipped affine-transform program through the
// inport handshake; outputs are checked against a queue of expected results.
module tb_pico_cpu;

    localparam int n = 8;

    logic         clk    = 1'b0;
    logic         nReset = 1'b1;
    logic [n:0]   inport = '0;
    logic [n-1:0] outport;

    int compared   = 0;
    int mismatched = 0;

    // Expected values are stored scaled by 4 so quarter-LSB exact results stay integral.
    logic signed [15:0] exp_q[$];
    int                 tol_q[$];
    string              name_q[$];

    pico_cpu #(.n(n)) uut (
        .clk     (clk),
        .nReset  (nReset),
        .inport  (inport),
        .outport (outport)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (compared %0d)", compared);
        $fatal(1, "watchdog expired");
    end

    // helpers and driver tasks
    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drive(input bit flag, input int data, input int cycles);
        logic [n-1:0] d;
        d      = n'(data);
        inport = {flag, d};
        repeat (cycles) @(negedge clk);
    endtask

    task automatic push_exp(input string name, input int exp4, input int tol4);
        exp_q.push_back(16'(exp4));
        tol_q.push_back(tol4);
        name_q.push_back(name);
    endtask

    // One full host transaction: x1 pulse, y1 pulse (x2 follows), ack pulse (y2 follows).
    task automatic send_point(input string name, input int x, input int y,
                              input int x2_exp4, input int x2_tol4,
                              input int y2_exp4, input int y2_tol4);
        push_exp({name, "_x2"}, x2_exp4, x2_tol4);
        push_exp({name, "_y2"}, y2_exp4, y2_tol4);
        drive(1'b1, x, 5);
        drive(1'b0, x, 5);
        drive(1'b1, y, 5);
        drive(1'b0, y, 5);
        drive(1'b1, y, 5);
        drive(1'b0, y, 5);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_progAddr"}, int'(uut.progAddr), 0);
        check({tag, "_outport"}, int'(outport), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_gpr%0d", tag, i), int'(uut.gpr.gpr[i]), 0);
        end
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        if (!nReset && uut.out_we) begin
            int got;
            int e4;
            int t4;
            int diff;
            string nm;
            #1;
            got = int'($signed(outport));
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_out: got %0d, expected no output", got);
            end else begin
                e4   = int'(exp_q.pop_front());
                t4   = tol_q.pop_front();
                nm   = name_q.pop_front();
                diff = 4 * got - e4;
                if (diff < -t4 || diff > t4) begin
                    mismatched++;
                    $display("FAIL %s: got %0d, expected %0d/4 within %0d/4", nm, got, e4, t4);
                end
            end
        end
    end

    // stimulus
    initial begin
        int x;
        int y;

        // reset held for two cycles
        idle(2);
        check_reset_state("reset");
        nReset = 1'b0;
        idle(3);

        // directed points (hand-computed, x4 scaling)
        send_point("p00", 0, 0, 80, 0, -80, 0);

        // long stall at the first WAITH; outport keeps the last y2
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("stall_progAddr", int'(uut.progAddr), 2);
        end
        check("stall_outport", int'($signed(outport)), -20);

        send_point("p10_20", 10, 20, 150, 2, -40, 0);
        send_point("pmin", -64, -64, -240, 0, -144, 0);
        send_point("pmax", 63, 63, 395, 3, -17, 3);

        // reset after x1 has been accepted
        drive(1'b1, 33, 5);
        drive(1'b0, 33, 2);
        nReset = 1'b1;
        idle(2);
        check_reset_state("midreset");
        nReset = 1'b0;
        idle(3);
        send_point("restart", 10, 20, 150, 2, -40, 0);

        // random points against the exact transform
        for (int k = 0; k < 10; k++) begin
            x = int'($urandom_range(0, 127)) - 64;
            y = int'($urandom_range(0, 127)) - 64;
            send_point($sformatf("rnd%0d", k), x, y,
                       3 * x + 2 * y + 80, 4, -2 * x + 3 * y - 80, 4);
        end

        // drain
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
        end
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
